// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared definitions for the multicycle RISC-V control unit: the
//          FSM state encoding (also exported on state_o), the opcode
//          constants, and the datapath mux / ALU-op encodings.
// Ports:   none (package).
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTER  = 4'd6,
        S_EXECUTEI  = 4'd7,
        S_ALUWB     = 4'd8,
        S_BEQ       = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_LINK = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Purpose: bundle between the multicycle controller and its datapath.
// Modports:
//   master - controller side: samples op/zero/mem_ready, drives all
//            datapath controls plus the state_o debug view.
//   slave  - datapath side: the mirror image.
interface multicycle_controller_if;

    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic       instr_done;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [3:0] state_o;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
               instr_done, result_src, alu_src_a, alu_src_b, alu_op,
               imm_src, state_o
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
               instr_done, result_src, alu_src_a, alu_src_b, alu_op,
               imm_src, state_o
    );

endinterface

// File: rtl/multicycle_controller_opdecode.sv
// Purpose: combinational opcode decode for the multicycle controller.
// Ports:
//   op       in  opcode field of the instruction register
//   dec_next out state to enter after DECODE (S_TRAP for illegal ops)
//   imm_src  out immediate format select
//   legal    out opcode is supported in this configuration
module mc_opdecode
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ENABLE_ITYPE = 1,
    parameter int unsigned ENABLE_JALR  = 1
) (
    input  logic [6:0] op,
    output state_t     dec_next,
    output logic [1:0] imm_src,
    output logic       legal
);

    always_comb begin
        dec_next = S_TRAP;
        imm_src  = IMM_I;
        legal    = 1'b0;
        case (op)
            OP_LOAD: begin
                dec_next = S_MEMADR;
                legal    = 1'b1;
            end
            OP_STORE: begin
                dec_next = S_MEMADR;
                imm_src  = IMM_S;
                legal    = 1'b1;
            end
            OP_RTYPE: begin
                dec_next = S_EXECUTER;
                legal    = 1'b1;
            end
            // imm_src keeps its I-format value even when the op is disabled
            OP_ITYPE: begin
                if (ENABLE_ITYPE != 0) begin
                    dec_next = S_EXECUTEI;
                    legal    = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec_next = S_BEQ;
                imm_src  = IMM_B;
                legal    = 1'b1;
            end
            OP_JAL: begin
                dec_next = S_JAL;
                imm_src  = IMM_J;
                legal    = 1'b1;
            end
            OP_JALR: begin
                if (ENABLE_JALR != 0) begin
                    dec_next = S_JALR;
                    legal    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle RISC-V control FSM. Holds the state register and the
//          Moore output decode; opcode decode lives in mc_opdecode.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset; while high all outputs except
//              state_o are forced to zero
//   bus    master modport of multicycle_controller_if (op/zero/mem_ready in,
//          datapath controls and state_o out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH      | read instruction, PC <= PC+4; waits for mem_ready
// DECODE     | read registers, compute branch target
// MEMADR     | compute load/store address
// MEMREAD    | load data read; waits for mem_ready
// MEMWB      | write loaded data to register file
// MEMWRITE   | store data write; waits for mem_ready
// EXECUTER   | R-type ALU operation
// EXECUTEI   | I-type ALU operation
// ALUWB      | write ALU result to register file
// BEQ        | compare, take branch when zero
// JAL        | PC <= target, compute link address
// JALR       | PC <= rs1+imm
// JALR_LINK  | compute link address OldPC+4
// TRAP       | illegal opcode; held until reset
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ENABLE_ITYPE = 1,
    parameter int unsigned ENABLE_JALR  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t     state;
    state_t     state_next;
    state_t     dec_next;
    logic [1:0] dec_imm_src;
    logic       dec_legal;

    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    mc_opdecode #(
        .ENABLE_ITYPE (ENABLE_ITYPE),
        .ENABLE_JALR  (ENABLE_JALR)
    ) u_opdecode (
        .op       (bus.op),
        .dec_next (dec_next),
        .imm_src  (dec_imm_src),
        .legal    (dec_legal)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE:    state_next = dec_legal ? dec_next : S_TRAP;
            S_MEMADR:    state_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:   if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:     state_next = S_FETCH;
            S_MEMWRITE:  if (bus.mem_ready) state_next = S_FETCH;
            S_EXECUTER:  state_next = S_ALUWB;
            S_EXECUTEI:  state_next = S_ALUWB;
            S_ALUWB:     state_next = S_FETCH;
            S_BEQ:       state_next = S_FETCH;
            S_JAL:       state_next = S_ALUWB;
            S_JALR:      state_next = S_JALR_LINK;
            S_JALR_LINK: state_next = S_ALUWB;
            S_TRAP:      state_next = S_TRAP;
            // unused encodings park in TRAP so a corrupted state is visible
            default:     state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Every field defaults to 00/0, which is also the forced value in reset.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    // IR and PC update only in the cycle the fetch completes
                    ir_write   = bus.mem_ready;
                    pc_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTER: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXECUTEI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    pc_write  = bus.zero;
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    result_src = RES_ALURESULT;
                    pc_write   = 1'b1;
                end
                S_JALR_LINK: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.ir_write   = ir_write;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.illegal    = illegal;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.imm_src    = reset ? 2'b00 : dec_imm_src;
    assign bus.instr_done = !reset && (state != S_FETCH) && (state_next == S_FETCH);
    assign bus.state_o    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] MA  = 4'd2;
    localparam logic [3:0] MR  = 4'd3;
    localparam logic [3:0] MWB = 4'd4;
    localparam logic [3:0] MW  = 4'd5;
    localparam logic [3:0] EXR = 4'd6;
    localparam logic [3:0] EXI = 4'd7;
    localparam logic [3:0] AWB = 4'd8;
    localparam logic [3:0] BQ  = 4'd9;
    localparam logic [3:0] JL  = 4'd10;
    localparam logic [3:0] JR  = 4'd11;
    localparam logic [3:0] JRL = 4'd12;
    localparam logic [3:0] TR  = 4'd13;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus_a ();
    multicycle_controller_if bus_b ();

    assign bus_a.op        = op;
    assign bus_a.zero      = zero;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.op        = op;
    assign bus_b.zero      = zero;
    assign bus_b.mem_ready = mem_ready;

    multicycle_controller #(.ENABLE_ITYPE(1), .ENABLE_JALR(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    multicycle_controller #(.ENABLE_ITYPE(1), .ENABLE_JALR(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // {state, pc_write, adr_src, ir_write, mem_write, reg_write, illegal,
    //  instr_done, result_src, alu_src_a, alu_src_b, alu_op, imm_src}
    logic [20:0] obs_a;
    logic [20:0] obs_b;
    assign obs_a = {bus_a.state_o, bus_a.pc_write, bus_a.adr_src, bus_a.ir_write,
                    bus_a.mem_write, bus_a.reg_write, bus_a.illegal, bus_a.instr_done,
                    bus_a.result_src, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op,
                    bus_a.imm_src};
    assign obs_b = {bus_b.state_o, bus_b.pc_write, bus_b.adr_src, bus_b.ir_write,
                    bus_b.mem_write, bus_b.reg_write, bus_b.illegal, bus_b.instr_done,
                    bus_b.result_src, bus_b.alu_src_a, bus_b.alu_src_b, bus_b.alu_op,
                    bus_b.imm_src};

    // One stimulus/expectation row: {reset, mem_ready, zero, expected obs}
    function automatic logic [23:0] r(input logic rst, mr, z, input logic [3:0] st,
                                      input logic pcw, adr, irw, mw, rw, ill, done,
                                      input logic [1:0] rs, a, b, aop, imm);
        return {rst, mr, z, st, pcw, adr, irw, mw, rw, ill, done, rs, a, b, aop, imm};
    endfunction

    task automatic test_reset();
        logic [23:0] rows [3];
        op = 7'b1100011;
        rows = '{
            r(1,1,1, F, 0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(1,0,0, F, 0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, F, 0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b10)
        };
        for (int i = 0; i < 3; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL reset row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        logic [23:0] rows [6];
        op = 7'b0000011;
        rows = '{
            r(0,1,0, F,   1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,1,0, D,   0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00),
            r(0,1,0, MA,  0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00),
            r(0,1,0, MR,  0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,1,0, MWB, 0,0,0,0,1,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, F,   0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00)
        };
        for (int i = 0; i < 6; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL load row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_store_wait();
        logic [23:0] rows [8];
        op = 7'b0100011;
        rows = '{
            r(0,1,0, F,  1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b01),
            r(0,1,0, D,  0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b01),
            r(0,1,0, MA, 0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01),
            r(0,0,0, MW, 0,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01),
            r(0,0,0, MW, 0,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01),
            r(0,0,0, MW, 0,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01),
            r(0,1,0, MW, 0,1,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b01),
            r(0,0,0, F,  0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b01)
        };
        for (int i = 0; i < 8; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL store row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_rtype_fetch_wait();
        logic [23:0] rows [7];
        op = 7'b0110011;
        rows = '{
            r(0,0,0, F,   0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,0,0, F,   0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,1,0, F,   1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,1,0, D,   0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00),
            r(0,1,0, EXR, 0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00),
            r(0,1,0, AWB, 0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, F,   0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00)
        };
        for (int i = 0; i < 7; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL rtype row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_itype();
        logic [23:0] rows [5];
        op = 7'b0010011;
        rows = '{
            r(0,1,0, F,   1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,1,0, D,   0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00),
            r(0,1,0, EXI, 0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00),
            r(0,1,0, AWB, 0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, F,   0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00)
        };
        for (int i = 0; i < 5; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL itype row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_beq();
        logic [23:0] rows [7];
        op = 7'b1100011;
        rows = '{
            r(0,1,1, F,  1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b10),
            r(0,1,1, D,  0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10),
            r(0,1,1, BQ, 1,0,0,0,0,0,1, 2'b00,2'b10,2'b00,2'b01,2'b10),
            r(0,1,0, F,  1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b10),
            r(0,1,0, D,  0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10),
            r(0,1,0, BQ, 0,0,0,0,0,0,1, 2'b00,2'b10,2'b00,2'b01,2'b10),
            r(0,0,1, F,  0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b10)
        };
        for (int i = 0; i < 7; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL beq row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_jal();
        logic [23:0] rows [5];
        op = 7'b1101111;
        rows = '{
            r(0,1,0, F,   1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b11),
            r(0,1,0, D,   0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b11),
            r(0,1,0, JL,  1,0,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b11),
            r(0,1,0, AWB, 0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,2'b11),
            r(0,0,0, F,   0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b11)
        };
        for (int i = 0; i < 5; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL jal row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_jalr();
        logic [23:0] rows [6];
        op = 7'b1100111;
        rows = '{
            r(0,1,0, F,   1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,1,0, D,   0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00),
            r(0,1,0, JR,  1,0,0,0,0,0,0, 2'b10,2'b10,2'b01,2'b00,2'b00),
            r(0,1,0, JRL, 0,0,0,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b00),
            r(0,1,0, AWB, 0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, F,   0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00)
        };
        for (int i = 0; i < 6; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL jalr row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    // dut_b has JALR disabled; it was left in TRAP by the previous jalr run
    task automatic test_jalr_disabled();
        logic [23:0] rows [7];
        op = 7'b1100111;
        rows = '{
            r(1,0,0, TR, 0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,1,0, F,  1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,1,0, D,  0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00),
            r(0,1,0, TR, 0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, TR, 0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(1,0,0, TR, 0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, F,  0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00)
        };
        for (int i = 0; i < 7; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_b !== rows[i][20:0]) $display("FAIL jalr_disabled row %0d: got %b expected %b", i, obs_b, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        logic [23:0] rows [14];
        op = 7'b0000000;
        rows[0] = r(0,1,0, F, 1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00);
        rows[1] = r(0,1,0, D, 0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00);
        for (int k = 2; k < 12; k++)
            rows[k] = r(0, k[0], k[1], TR, 0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
        rows[12] = r(1,1,0, TR, 0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
        rows[13] = r(0,0,0, F,  0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00);
        for (int i = 0; i < 14; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL trap row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midwait();
        logic [23:0] rows [8];
        op = 7'b0000011;
        rows = '{
            r(0,1,0, F,  1,0,1,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00),
            r(0,1,0, D,  0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00),
            r(0,1,0, MA, 0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00),
            r(0,0,0, MR, 0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, MR, 0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(1,0,0, MR, 0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(1,1,1, F,  0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00),
            r(0,0,0, F,  0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00)
        };
        for (int i = 0; i < 8; i++) begin
            reset = rows[i][23]; mem_ready = rows[i][22]; zero = rows[i][21];
            #1;
            n_checks++;
            if (obs_a !== rows[i][20:0]) $display("FAIL reset_midwait row %0d: got %b expected %b", i, obs_a, rows[i][20:0]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        op        = 7'b0000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_load();
        test_store_wait();
        test_rtype_fetch_wait();
        test_itype();
        test_beq();
        test_jal();
        test_jalr();
        test_jalr_disabled();
        test_trap();
        test_reset_midwait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
